// File: rtl/shr_deser.sv
// shr_deser: serial-to-parallel receiver for the SHR link with valid/ack handshake and sticky overrun.
// Ports: clk, rst_n (async, active-low); en (bit strobe), frame (first bit of word), l_nr (1 MSB first),
//        sin (serial data), ack (consumer accept); pout (word), valid, busy, ovr (sticky), par_err.
// Macro SHR_DESER_PARITY_EN adds a trailing even-parity bit per word and drives par_err.
module shr_deser #(
  parameter int N_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             frame,
  input  logic             l_nr,
  input  logic             sin,
  input  logic             ack,
  output logic [N_BIT-1:0] pout,
  output logic             valid,
  output logic             busy,
  output logic             ovr,
  output logic             par_err
);
  localparam int CW = $clog2(N_BIT + 1);
`ifdef SHR_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state, state_n;
  logic [N_BIT-1:0] shreg, shreg_n, sh, word;
  logic [CW-1:0] cnt, cnt_n;
  logic dir, dir_e, start, step, last, done, perr;
  assign start = en & frame;
  assign step  = en & ~frame & (state != IDLE);
  assign dir_e = start ? l_nr : dir;
  assign sh    = dir_e ? {shreg[N_BIT-2:0], sin} : {sin, shreg[N_BIT-1:1]};
  assign last  = step & (state == SHIFT) & (cnt == CW'(N_BIT - 1));
  assign busy  = state != IDLE;
  always_comb begin
`ifdef SHR_DESER_PARITY_EN
    done    = step & (state == PAR);
    word    = shreg;
    perr    = ^{shreg, sin};
    state_n = start ? SHIFT : last ? PAR : done ? IDLE : state;
`else
    done    = last;
    word    = sh;
    perr    = 1'b0;
    state_n = start ? SHIFT : done ? IDLE : state;
`endif
    shreg_n = (start | (step & (state == SHIFT))) ? sh : shreg;
    cnt_n   = start ? CW'(1) : done ? '0 : (step & (state == SHIFT)) ? cnt + CW'(1) : cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      pout    <= '0;
      valid   <= 1'b0;
      ovr     <= 1'b0;
      par_err <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      dir   <= dir_e;
      // A completing word is dropped only if the held word is still unacknowledged.
      if (done && valid && !ack) ovr <= 1'b1;
      else if (done) begin
        pout    <= word;
        valid   <= 1'b1;
        par_err <= perr;
      end else if (ack) valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shr_deser.sv
// tb_shr_deser: directed and random stimulus for shr_deser against a bit-list reference model.
module tb_shr_deser;
  localparam int N = 4;
`ifdef SHR_DESER_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  logic clk = 0, rst_n = 0, en = 0, frame = 0, l_nr = 0, sin = 0, ack = 0;
  logic [N-1:0] pout;
  logic valid, busy, ovr, par_err;
  int errs = 0, checks = 0;
  bit m_bits[$];
  bit m_dir, m_valid, m_ovr, m_pe;
  logic [N-1:0] m_pout;

  shr_deser #(.N_BIT(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame(frame), .l_nr(l_nr), .sin(sin), .ack(ack),
    .pout(pout), .valid(valid), .busy(busy), .ovr(ovr), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_bits.delete();
    m_dir = 0; m_valid = 0; m_ovr = 0; m_pe = 0; m_pout = '0;
  endtask

  task automatic model_step(bit e, bit f, bit l, bit s, bit a);
    bit done = 0, pe = 0;
    logic [N-1:0] w = '0;
    if (e && f) begin
      m_bits.delete();
      m_bits.push_back(s);
      m_dir = l;
    end else if (e && m_bits.size() > 0) begin
      m_bits.push_back(s);
      if (m_bits.size() == NB) begin
        done = 1;
        for (int i = 0; i < N; i++)
          if (m_dir) w[N-1-i] = m_bits[i]; else w[i] = m_bits[i];
`ifdef SHR_DESER_PARITY_EN
        for (int i = 0; i < NB; i++) pe ^= m_bits[i];
`endif
        m_bits.delete();
      end
    end
    if (done) begin
      if (m_valid && !a) m_ovr = 1;
      else begin
        m_pout = w; m_valid = 1; m_pe = pe;
      end
    end else if (a && m_valid) m_valid = 0;
  endtask

  task automatic chk(string tag, logic [N-1:0] p, logic v, logic b, logic o, logic pe);
    checks++;
    assert ({pout, valid, busy, ovr, par_err} === {p, v, b, o, pe})
    else begin
      errs++;
      $error("FAIL %s: pout/valid/busy/ovr/par_err got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
             tag, pout, valid, busy, ovr, par_err, p, v, b, o, pe);
    end
  endtask

  task automatic chk_model(string tag);
    chk(tag, m_pout, m_valid, m_bits.size() > 0, m_ovr, m_pe);
  endtask

  task automatic cyc(bit e, bit f, bit l, bit s, bit a, string tag);
    en = e; frame = f; l_nr = l; sin = s; ack = a;
    @(posedge clk);
    model_step(e, f, l, s, a);
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 0;
    en = 0; frame = 0; ack = 0;
    #1;
    model_reset();
    chk("reset", '0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Sends a framed word in the chosen bit order; bad_par inverts the trailing parity bit.
  task automatic send_word(logic [N-1:0] w, bit l, bit ack_last, bit bad_par, string tag);
    bit b;
    for (int i = 0; i < NB; i++) begin
      b = (i < N) ? (l ? w[N-1-i] : w[i]) : ((^w) ^ bad_par);
      cyc(1, i == 0, l, b, ack_last && (i == NB - 1), tag);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    send_word(4'hB, 1, 0, 0, "msb_first");
    chk("msb_B", 4'hB, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, "hold");
    cyc(1, 0, 0, 1, 0, "idle_en_ignored");
    chk("held_B", 4'hB, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, "ack_B");
    chk("acked_B", 4'hB, 0, 0, 0, 0);
    send_word(4'hD, 0, 0, 0, "lsb_first");
    chk("lsb_D", 4'hD, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, "ack_D");
    chk("acked_D", 4'hD, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, "ack_idle");
    send_word(4'h6, 1, 0, 0, "loopback");
    chk("loop_6", 4'h6, 1, 0, 0, 0);
    do_reset();
    send_word(4'hA, 1, 0, 0, "ovr_a");
    send_word(4'h5, 1, 0, 0, "ovr_5");
    chk("overrun", 4'hA, 1, 0, 1, 0);
    do_reset();
    send_word(4'hA, 1, 0, 0, "b2b_a");
    send_word(4'h5, 1, 1, 0, "b2b_5");
    chk("back2back", 4'h5, 1, 0, 0, 0);
    do_reset();
    cyc(1, 1, 1, 1, 0, "abort_b1");
    cyc(1, 0, 0, 1, 0, "abort_b2");
    send_word(4'h6, 1, 0, 0, "after_abort");
    chk("abort_6", 4'h6, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, "mid_b1");
    cyc(1, 0, 1, 0, 0, "mid_b2");
    chk("mid_busy", 4'h6, 1, 1, 0, 0);
    do_reset();
`ifdef SHR_DESER_PARITY_EN
    send_word(4'hB, 1, 0, 0, "par_ok");
    chk("par_ok", 4'hB, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, "par_ack");
    send_word(4'hB, 1, 0, 1, "par_bad");
    chk("par_bad", 4'hB, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, "par_ack2");
`endif
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 9) < 3, "random");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
